// File: rtl/axi_write_packer_if.sv
// ---------------------------------------------------------------------------
// axi_write_packer_if
//
// AXI4-Stream beat bundle for the write-path output of axi_write_packer.
//
// Signals:
//   tvalid  beat valid (master -> slave)
//   tready  downstream ready (slave -> master)
//   tdata   packed beat, record k in bits [32k+31:32k]
//   tkeep   byte enables
//   tlast   final beat of the stream
//
// Modports: master (packer side), slave (downstream / memory writer side).
// ---------------------------------------------------------------------------
interface axi_write_packer_if #(
   parameter int C_AXIS_TDATA_WIDTH = 512
);

   logic                              tvalid;
   logic                              tready;
   logic [C_AXIS_TDATA_WIDTH-1:0]     tdata;
   logic [C_AXIS_TDATA_WIDTH/8-1:0]   tkeep;
   logic                              tlast;

   modport master (
      output tvalid,
      output tdata,
      output tkeep,
      output tlast,
      input  tready
   );

   modport slave (
      input  tvalid,
      input  tdata,
      input  tkeep,
      input  tlast,
      output tready
   );

endinterface

// File: rtl/axi_write_packer.sv
// ---------------------------------------------------------------------------
// axi_write_packer
//
// Drains C_SORTER_BIT_WIDTH-bit sorted records from a first-word-fall-through
// output FIFO and packs LANES = C_AXIS_TDATA_WIDTH/C_SORTER_BIT_WIDTH of them
// into each AXI4-Stream beat. A record value of 0 is the end-of-stream
// sentinel: it is popped without being stored and flushes a final beat with
// tlast=1 (unused lanes zero; an empty final beat is all-zero data).
//
// Ports:
//   m_axis_aclk     clock
//   m_axis_aresetn  asynchronous active-low reset
//   fifo_empty      output FIFO empty flag (FWFT)
//   out_fifo_data   head record, valid while fifo_empty=0
//   out_fifo_rd_en  pops the head record (combinational)
//   m_axis          axi_write_packer_if.master: tvalid/tready/tdata/tkeep/tlast
//
// Build option:
//   AXI_WRITE_PACKER_TKEEP_EN  when defined, the tlast beat enables only the
//                              bytes of filled lanes (empty final beat -> 0);
//                              otherwise tkeep is all-ones on every beat.
// ---------------------------------------------------------------------------
module axi_write_packer #(
   parameter int C_AXIS_TDATA_WIDTH = 512,
   parameter int C_SORTER_BIT_WIDTH = 32
) (
   input  logic                          m_axis_aclk,
   input  logic                          m_axis_aresetn,
   input  logic                          fifo_empty,
   input  logic [C_SORTER_BIT_WIDTH-1:0] out_fifo_data,
   output logic                          out_fifo_rd_en,
   axi_write_packer_if.master            m_axis
);

   localparam int LANES  = C_AXIS_TDATA_WIDTH / C_SORTER_BIT_WIDTH;
   localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int KEEP_W = C_AXIS_TDATA_WIDTH / 8;
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

   typedef enum logic {
      ACCUM = 1'b0,
      SEND  = 1'b1
   } state_e;

   state_e                        state_q,    state_d;
   logic [LANE_W-1:0]             lane_cnt_q, lane_cnt_d;
   logic [C_AXIS_TDATA_WIDTH-1:0] acc_q,      acc_d;
   logic [C_AXIS_TDATA_WIDTH-1:0] tdata_q,    tdata_d;
   logic [KEEP_W-1:0]             tkeep_q,    tkeep_d;
   logic                          tvalid_q,   tvalid_d;
   logic                          tlast_q,    tlast_d;

   logic                          rec_is_sentinel;
   logic [C_AXIS_TDATA_WIDTH-1:0] acc_ins;
   logic [KEEP_W-1:0]             final_keep;

   assign rec_is_sentinel = (out_fifo_data == '0);

   // Accumulator with the head record written into the current lane.
   always_comb begin
      acc_ins = acc_q;
      for (int unsigned k = 0; k < LANES; k++) begin
         if (LANE_W'(k) == lane_cnt_q) begin
            acc_ins[k*C_SORTER_BIT_WIDTH +: C_SORTER_BIT_WIDTH] = out_fifo_data;
         end
      end
   end

   // Byte enables for the tlast beat; lane_cnt_q is the number of filled lanes.
`ifdef AXI_WRITE_PACKER_TKEEP_EN
   localparam int BYTES_PER_LANE = C_SORTER_BIT_WIDTH / 8;
   always_comb begin
      final_keep = '0;
      for (int unsigned k = 0; k < LANES; k++) begin
         if (LANE_W'(k) < lane_cnt_q) begin
            final_keep[k*BYTES_PER_LANE +: BYTES_PER_LANE] = '1;
         end
      end
   end
`else
   assign final_keep = '1;
`endif

   // State register and datapath flops.
   always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
      if (!m_axis_aresetn) begin
         state_q    <= ACCUM;
         lane_cnt_q <= '0;
         acc_q      <= '0;
         tdata_q    <= '0;
         tkeep_q    <= '0;
         tvalid_q   <= 1'b0;
         tlast_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         lane_cnt_q <= lane_cnt_d;
         acc_q      <= acc_d;
         tdata_q    <= tdata_d;
         tkeep_q    <= tkeep_d;
         tvalid_q   <= tvalid_d;
         tlast_q    <= tlast_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ACCUM: begin
            if (!fifo_empty && (rec_is_sentinel || lane_cnt_q == LAST_LANE)) begin
               state_d = SEND;
            end
         end
         SEND: begin
            if (m_axis.tready) begin
               state_d = ACCUM;
            end
         end
         default: state_d = ACCUM;
      endcase
   end

   // Output / datapath logic.
   always_comb begin
      out_fifo_rd_en = (state_q == ACCUM) && !fifo_empty;
      lane_cnt_d     = lane_cnt_q;
      acc_d          = acc_q;
      tdata_d        = tdata_q;
      tkeep_d        = tkeep_q;
      tvalid_d       = tvalid_q;
      tlast_d        = tlast_q;

      unique case (state_q)
         ACCUM: begin
            if (out_fifo_rd_en) begin
               if (!rec_is_sentinel) begin
                  acc_d      = acc_ins;
                  lane_cnt_d = lane_cnt_q + LANE_W'(1);
                  if (lane_cnt_q == LAST_LANE) begin
                     tdata_d  = acc_ins;
                     tkeep_d  = '1;
                     tvalid_d = 1'b1;
                     tlast_d  = 1'b0;
                  end
               end else begin
                  // Sentinel is consumed but never stored; unused lanes are
                  // already zero because the accumulator clears per beat.
                  tdata_d  = acc_q;
                  tkeep_d  = final_keep;
                  tvalid_d = 1'b1;
                  tlast_d  = 1'b1;
               end
            end
         end
         SEND: begin
            if (m_axis.tready) begin
               tvalid_d   = 1'b0;
               tlast_d    = 1'b0;
               acc_d      = '0;
               lane_cnt_d = '0;
            end
         end
         default: ;
      endcase
   end

   assign m_axis.tvalid = tvalid_q;
   assign m_axis.tdata  = tdata_q;
   assign m_axis.tkeep  = tkeep_q;
   assign m_axis.tlast  = tlast_q;

endmodule

// File: doc/axi_write_packer.md
Name: axi_write_packer

Overview:
- Output-side counterpart of the input unpacker. It drains 32-bit sorted records from the merger-tree output FIFO and packs 16 of them into each 512-bit AXI4-Stream beat for the write path to memory.
- A record value of 0 is the end-of-stream sentinel, matching the extra 0 the input side appends after tlast. On the sentinel, the block flushes a final beat with m_axis_tlast=1.

Parameters:
- C_AXIS_TDATA_WIDTH, 512: width of the AXIS beat in bits.
- C_SORTER_BIT_WIDTH, 32: width of one record in bits. C_AXIS_TDATA_WIDTH must be an integer multiple of it.
- Derived: LANES = C_AXIS_TDATA_WIDTH/C_SORTER_BIT_WIDTH (16). Lane index width = clog2(LANES).

Ports:
- m_axis_aclk  in  1  clock.
- m_axis_aresetn  in  1  reset; asynchronous assert, active-low.
- fifo_empty  in  1  output FIFO empty flag. The FIFO is first-word-fall-through.
- out_fifo_data  in  C_SORTER_BIT_WIDTH  head record; valid while fifo_empty=0.
- out_fifo_rd_en  out  1  pops the head record.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  C_AXIS_TDATA_WIDTH  packed beat. Record k of the beat sits in bits [32k+31:32k].
- m_axis_tkeep  out  C_AXIS_TDATA_WIDTH/8  byte enables.
- m_axis_tlast  out  1  final beat of the stream.

Behaviour:
- Reset (m_axis_aresetn=0, asynchronous) clears all of the following:
  - state to ACCUM, lane counter to 0, accumulator to 0;
  - m_axis_tvalid, m_axis_tlast, m_axis_tdata and m_axis_tkeep all to 0.
  - Any partial beat is discarded. Reset mid-handshake drops tvalid immediately.
- out_fifo_rd_en is combinational: (state==ACCUM) & ~fifo_empty. Every cycle it is high, exactly one record is consumed.
- State ACCUM:
  - If fifo_empty, hold everything.
  - If the record is nonzero: write it into lane[lane_cnt] and increment lane_cnt.
    - If lane_cnt was LANES-1: register the beat onto m_axis_tdata, set tvalid=1, tlast=0, tkeep all-ones, and go to SEND.
  - If the record is 0 (sentinel): pop it without storing, register the beat with tvalid=1, tlast=1, and go to SEND.
    - Unused lanes are zero.
    - tkeep follows the Optional Feature.
    - If lane_cnt==0 the final beat carries no records (all-zero data).
- State SEND:
  - Outputs are held stable and no pops occur while m_axis_tready=0.
  - On tvalid & tready: in the same edge, clear tvalid, tlast, accumulator and lane_cnt, and return to ACCUM.
- Latency: tvalid rises on the clock edge that pops the 16th record (or the sentinel); that pop cycle is the last cycle in ACCUM.
- Throughput:
  - Full beat: LANES pop cycles plus at least 1 SEND cycle, so at most 1 beat per 17 cycles.
  - Stream of N nonzero records: emits ceil(N/16) beats with tlast=0 on all but the last.
  - When N is a multiple of 16, one extra all-zero beat carries tlast (i.e. floor(N/16)+1 beats in total).
- fifo_empty may toggle arbitrarily; lanes fill only on actual pops, with no bubbles or duplicates.
- Back-to-back streams: after a tlast beat the block returns to ACCUM and starts the next stream at lane 0.
- Nonzero records after a sentinel are never merged into the previous stream.

Optional Feature:
- Macro: AXI_WRITE_PACKER_TKEEP_EN.
- Defined:
  - m_axis_tkeep on the tlast beat sets 4 bytes per filled lane (lanes 0..lane_cnt-1) and clears the rest.
  - An empty final beat has tkeep=0.
  - Non-final beats use all-ones.
- Undefined:
  - m_axis_tkeep is all-ones on every beat.
  - Padding lanes are delivered as 0 records, which downstream treats as data/terminators.

Test Plan:
1. Push 1..16 then 0 with tready=1. Required response:
   - Beat A has lane k = k+1 and tlast=0.
   - Beat B has all-zero data and tlast=1.
   - B's tkeep is 0 with the macro, all-ones without it.
2. Push 5,6,7,0. Required response:
   - One beat with lanes 0..2 = 5,6,7, the rest 0, and tlast=1.
   - tkeep = 0xFFF with the macro.
3. Fill 16 records, then hold tready=0 for 10 cycles with the FIFO non-empty. Required response:
   - tdata, tkeep and tlast are stable.
   - out_fifo_rd_en=0 throughout.
   - One cycle after tready=1, the next pop occurs.
4. Assert fifo_empty on alternating cycles while pushing 1..20 then 0. Required response:
   - Beat 1 = 1..16 with tlast=0.
   - Beat 2 = 17..20 padded with zeros, tlast=1.
   - No duplicated or missing records.
5. Assert m_axis_aresetn low after 7 records, then release and push 9,0. Required response:
   - tvalid=0 during reset.
   - The next beat holds only 9 in lane 0, with tlast=1.
6. Send two streams back to back: 1,2,0 then 3,0. Required response:
   - Two tlast beats: lanes (1,2) and (3).
   - Record 3 appears in lane 0 of the second beat.
